mp_add_sequencer: RTL and testbench
===================================

// Module: mp_add_sequencer
// PURPOSE
//  Multi-precision adder controller. Accepts two WORDS*16-bit operands, then adds them
//  16 bits per cycle on one shared 16-bit ripple-carry adder, least significant word first.
//  A registered carry links each word to the next.
//  Sits between the operand source and the result sink. Valid/ready on both sides.
// PARAMETERS
//  WORDS  4   number of 16-bit words per operand (>=1); operand width = WORDS*16
// PORTS
//  CLK        in   1         clock; all state updates on the rising edge
//  RST_N      in   1         asynchronous, active-low reset
//  IN_VALID   in   1         operands/CIN valid
//  IN_READY   out  1         sequencer can accept operands
//  A          in   WORDS*16  operand A
//  B          in   WORDS*16  operand B
//  CIN        in   1         carry into word 0
//  OUT_VALID  out  1         SUM/COUT valid
//  OUT_READY  in   1         sink accepts result
//  SUM        out  WORDS*16  result, modulo 2^(WORDS*16)
//  COUT       out  1         carry out of the top word
//  BUSY       out  1         high in RUN
// BEHAVIOUR
//  - Reset (async, RST_N=0): state=IDLE; idx=0; carry reg=0.
//    Outputs: IN_READY=1, OUT_VALID=0, SUM=0, COUT=0, BUSY=0.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: IN_READY=1. On IN_VALID&IN_READY: latch A, B; carry<=CIN; idx<=0; go to RUN.
//    RUN: IN_READY=0, BUSY=1. Each cycle: word idx of {SUM,carry} <= A[idx]+B[idx]+carry.
//      If idx==WORDS-1: COUT<=adder carry; go to DONE. Else idx<=idx+1.
//    DONE: OUT_VALID=1. SUM and COUT are held stable until OUT_READY=1, then go to IDLE.
//  - Latency: if acceptance is at edge 0, OUT_VALID rises after edge WORDS.
//    Throughput: one operation per WORDS+2 cycles with OUT_READY tied high.
//  - IN_READY is low in RUN and DONE. No new acceptance in the cycle DONE->IDLE.
//    The earliest new accept is the next cycle.
//  - SUM holds the previous result until overwritten word by word in the next RUN.
//    SUM is valid only while OUT_VALID=1.
//  - idx counter width max(1,$clog2(WORDS)). WORDS=1: RUN lasts exactly one cycle.
//  - Backpressure: OUT_VALID stays high indefinitely while OUT_READY=0. No result is dropped.
//  - Asynchronous reset in RUN or DONE aborts the operation. Every output returns to its
//    reset value immediately. No partial result is ever presented.
//  - A/B/CIN are sampled only at acceptance; later changes are ignored.
// CONFIGURATION
//  MPADD_SUB_EN defined: adds input port SUB (1 bit), sampled with the operands.
//    SUB=1 computes A-B: B words are inverted into the adder and the initial carry is forced
//    to 1 (CIN ignored). COUT=1 means no borrow. SUB=0 behaves as plain add.
//  MPADD_SUB_EN undefined: no SUB port; add only.
// STRUCTURE
//  Package mpadd_pkg: state typedef {IDLE,RUN,DONE}; constant DW=16.
//  Sub-module: exactly one instance of the team's 16-bit ripple-carry adder RCA16b.
//  It is fed by idx-selected word muxes. Its carry-in is the carry register.
//  No other arithmetic is inferred.
// TESTING
//  1 Reset: RST_N=0 -> IN_READY=1, OUT_VALID=0, SUM=0, COUT=0, BUSY=0.
//  2 WORDS=4: A=0x0000_0000_0000_FFFF, B=1, CIN=0 -> SUM=0x0000_0000_0001_0000, COUT=0.
//    OUT_VALID rises exactly 4 edges after accept.
//  3 Full-width ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, CIN=1 -> SUM=0, COUT=1.
//  4 Backpressure: OUT_READY=0 for 10 cycles -> SUM and OUT_VALID stable, IN_READY=0.
//    Then OUT_READY=1 -> IDLE next cycle; the next IN_VALID is accepted one cycle later.
//  5 Reset mid-RUN: assert RST_N=0 at idx=2 -> all outputs at reset values at once.
//    A following op with A=5, B=7 -> SUM=12.
//  6 MPADD_SUB_EN, SUB=1: A=3, B=5 -> SUM=0xFFFF_FFFF_FFFF_FFFE, COUT=0.
//    A=5, B=3 -> SUM=2, COUT=1.

Source files
------------

// File: rtl/mp_add_sequencer_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
package mpadd_pkg;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mp_add_sequencer_if.sv
// Operand/result handshake bundle for mp_add_sequencer.
// MPADD_SUB_EN adds the 'sub' request bit alongside the operands.
interface mp_add_sequencer_if #(parameter int WORDS = 4);
  logic                          inValid;
  logic                          inReady;
  logic [WORDS*mpadd_pkg::DW-1:0] a;
  logic [WORDS*mpadd_pkg::DW-1:0] b;
  logic                          cin;
`ifdef MPADD_SUB_EN
  logic                          sub;
`endif
  logic                          outValid;
  logic                          outReady;
  logic [WORDS*mpadd_pkg::DW-1:0] sum;
  logic                          cout;
  logic                          busy;

  modport master (
`ifdef MPADD_SUB_EN
    output sub,
`endif
    output inValid, a, b, cin, outReady,
    input  inReady, outValid, sum, cout, busy
  );

  modport slave (
`ifdef MPADD_SUB_EN
    input  sub,
`endif
    input  inValid, a, b, cin, outReady,
    output inReady, outValid, sum, cout, busy
  );
endinterface

// File: rtl/mp_add_sequencer_rca.sv
// 16-bit ripple-carry adder built from a chain of full-adder bit cells.
module RCA16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [16:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[16];
endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision adder: latches two WORDS*16-bit operands, then walks one
// shared 16-bit ripple adder across the words, LSW first, chaining a carry reg.
// MPADD_SUB_EN: optional subtract mode (invert B, force initial carry to 1).
module mp_add_sequencer
  import mpadd_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic               clk,
  input logic               rst_n,
  mp_add_sequencer_if.slave bus
);
  localparam int W  = WORDS * DW;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t          state, stateNxt;
  logic [W-1:0]    aReg, bReg, sumReg;
  logic [IW-1:0]   idx;
  logic            carry, coutReg;
  logic [DW-1:0]   aWord, bWord, addSum;
  logic            addCout, accept, lastWord, initCarry;
`ifdef MPADD_SUB_EN
  logic            subReg;
`endif

  assign accept   = bus.inValid && (state == IDLE);
  assign lastWord = (idx == IW'(WORDS - 1));

`ifdef MPADD_SUB_EN
  assign initCarry = bus.sub ? 1'b1 : bus.cin;
  assign bWord     = subReg ? ~bReg[DW*int'(idx) +: DW] : bReg[DW*int'(idx) +: DW];
`else
  assign initCarry = bus.cin;
  assign bWord     = bReg[DW*int'(idx) +: DW];
`endif
  assign aWord = aReg[DW*int'(idx) +: DW];

  RCA16b u_rca (
    .a  (aWord),
    .b  (bWord),
    .ci (carry),
    .s  (addSum),
    .co (addCout)
  );

  // State register; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  // Next-state: RUN for WORDS cycles, DONE holds until the sink takes it.
  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (accept) stateNxt = RUN;
      RUN:     if (lastWord) stateNxt = DONE;
      DONE:    if (bus.outReady) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then write one result word per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg    <= '0;
      bReg    <= '0;
      sumReg  <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      coutReg <= 1'b0;
`ifdef MPADD_SUB_EN
      subReg  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        aReg  <= bus.a;
        bReg  <= bus.b;
        carry <= initCarry;
        idx   <= '0;
`ifdef MPADD_SUB_EN
        subReg <= bus.sub;
`endif
      end
    end else if (state == RUN) begin
      sumReg[DW*int'(idx) +: DW] <= addSum;
      carry <= addCout;
      if (lastWord) coutReg <= addCout;
      else          idx     <= idx + IW'(1);
    end
  end

  assign bus.inReady  = (state == IDLE);
  assign bus.busy     = (state == RUN);
  assign bus.outValid = (state == DONE);
  assign bus.sum      = sumReg;
  assign bus.cout     = coutReg;
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: directed operations plus a transaction-level
// model checked on every falling edge. MPADD_SUB_EN enables the subtract cases.
module tb_mp_add_sequencer;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mp_add_sequencer_if #(.WORDS(WORDS)) bus ();

  mp_add_sequencer #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted operation finishes WORDS cycles later with the full
  // arithmetic result; it is presented until the sink takes it.
  bit           mPending = 1'b0;
  int           mCnt     = 0;
  logic [W:0]   mFull;

  always @(negedge clk) begin
    if (!rst_n) begin
      mPending = 1'b0;
      mCnt     = 0;
      chk("mdl_rst_inReady",  bus.inReady,  1);
      chk("mdl_rst_outValid", bus.outValid, 0);
      chk("mdl_rst_busy",     bus.busy,     0);
      chk("mdl_rst_sum",      bus.sum,      0);
      chk("mdl_rst_cout",     bus.cout,     0);
    end else begin
      bit expValid, expBusy, expReady;
      expValid = mPending && (mCnt >= WORDS);
      expBusy  = mPending && (mCnt <  WORDS);
      expReady = !mPending;
      chk("mdl_inReady",  bus.inReady,  expReady);
      chk("mdl_busy",     bus.busy,     expBusy);
      chk("mdl_outValid", bus.outValid, expValid);
      if (expValid) begin
        chk("mdl_sum",  bus.sum,  mFull[W-1:0]);
        chk("mdl_cout", bus.cout, mFull[W]);
      end
      if (expReady && bus.inValid) begin
        mPending = 1'b1;
        mCnt     = 0;
`ifdef MPADD_SUB_EN
        if (bus.sub) mFull = {1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1);
        else         mFull = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
`else
        mFull = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
`endif
      end else if (mPending) begin
        if (expValid && bus.outReady) mPending = 1'b0;
        else if (!expValid)           mCnt++;
      end
    end
  end

  // One full operation; called at posedge+1 with the DUT idle.
  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic ts, input int holdCycles,
                       output logic [W-1:0] rs, output logic rc, output int lat);
    int guard;
    guard = 0;
    while (!bus.inReady && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) chk("wait_inReady_timeout", 0, 1);
    bus.a = ta; bus.b = tb_; bus.cin = tc;
`ifdef MPADD_SUB_EN
    bus.sub = ts;
`else
    if (ts) $display("note: subtract request ignored in add-only build");
`endif
    bus.inValid = 1'b1;
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.cin = ~tc;
    chk("accept_busy", bus.busy, 1);
    lat = 0;
    while (!bus.outValid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 100) chk("wait_outValid_timeout", 0, 1);
    rs = bus.sum; rc = bus.cout;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk); #1;
      chk("hold_sum",      bus.sum,      rs);
      chk("hold_outValid", bus.outValid, 1);
      chk("hold_inReady",  bus.inReady,  0);
    end
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    bus.outReady = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat;

    rst_n = 1'b0;
    bus.inValid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.outReady = 1'b0;
`ifdef MPADD_SUB_EN
    bus.sub = 1'b0;
`endif
    #2;
    chk("reset_inReady",  bus.inReady,  1);
    chk("reset_outValid", bus.outValid, 0);
    chk("reset_sum",      bus.sum,      0);
    chk("reset_cout",     bus.cout,     0);
    chk("reset_busy",     bus.busy,     0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry out of word 0 into word 1.
    runOp(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, rs, rc, lat);
    chk("t2_sum",     rs,  64'h0000_0000_0001_0000);
    chk("t2_cout",    rc,  0);
    chk("t2_latency", lat, 4);
    chk("t2_idle_after", bus.inReady, 1);

    // Carry rippling through every word.
    runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, rs, rc, lat);
    chk("t3_sum",  rs, 64'h0);
    chk("t3_cout", rc, 1);

    // Backpressure, then back-to-back accept.
    runOp(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 10, rs, rc, lat);
    chk("t4_sum",       rs, 64'h1234_6789_BCDF_1233);
    chk("t4_cout",      rc, 0);
    chk("t4_inReady",   bus.inReady,  1);
    chk("t4_outValid",  bus.outValid, 0);
    runOp(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 0, rs, rc, lat);
    chk("t4b_sum",  rs, 64'h0000_0000_0000_0002);
    chk("t4b_cout", rc, 1);

    // Reset while RUN is at word 2.
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h1; bus.cin = 1'b0; bus.inValid = 1'b1;
    @(posedge clk); #1 bus.inValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_inReady",  bus.inReady,  1);
    chk("t5_outValid", bus.outValid, 0);
    chk("t5_sum",      bus.sum,      0);
    chk("t5_cout",     bus.cout,     0);
    chk("t5_busy",     bus.busy,     0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    runOp(64'h5, 64'h7, 1'b0, 1'b0, 0, rs, rc, lat);
    chk("t5_after_sum",  rs, 64'd12);
    chk("t5_after_cout", rc, 0);

`ifdef MPADD_SUB_EN
    runOp(64'h3, 64'h5, 1'b0, 1'b1, 0, rs, rc, lat);
    chk("t6_sub_neg_sum",  rs, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t6_sub_neg_cout", rc, 0);
    runOp(64'h5, 64'h3, 1'b0, 1'b1, 0, rs, rc, lat);
    chk("t6_sub_pos_sum",  rs, 64'h2);
    chk("t6_sub_pos_cout", rc, 1);
    runOp(64'h5, 64'h3, 1'b1, 1'b0, 0, rs, rc, lat);
    chk("t6_add_sum",  rs, 64'h9);
    chk("t6_add_cout", rc, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
